// File: rtl/seg7_scan_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg: shared types and constants for the seven-segment scan controller.
//   nibble_t   - one hex digit as presented to the decoder D inputs
//   ANODE_OFF  - all anodes released (active low); sliced to the digit count,
//                so displays of up to 32 digits are supported
//   idx_width  - width of the digit index counter for a given digit count
// ---------------------------------------------------------------------------
package seg7_pkg;

    typedef logic [3:0] nibble_t;

    localparam logic [31:0] ANODE_OFF = '1;

    function automatic int idx_width(input int digits);
        return (digits < 2) ? 1 : $clog2(digits);
    endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// ---------------------------------------------------------------------------
// seg7_scan_ctrl_if: load-side bus between the SoC display register (master)
// and the scan controller (slave).
//   load       master->slave  one-cycle capture strobe
//   hex_in     master->slave  nibble k in bits [4k+3:4k]
//   point_in   master->slave  decimal point per digit, 1 = lit
//   blank_in   master->slave  blank per digit, 1 = dark
//   pending    slave->master  captured data waiting for the frame boundary
//   frame_done slave->master  one-cycle pulse after each frame boundary
// ---------------------------------------------------------------------------
interface seg7_scan_ctrl_if #(
    parameter int DIGITS = 8
);
    logic                  load;
    logic [4*DIGITS-1:0]   hex_in;
    logic [DIGITS-1:0]     point_in;
    logic [DIGITS-1:0]     blank_in;
    logic                  pending;
    logic                  frame_done;

    modport master (
        output load, hex_in, point_in, blank_in,
        input  pending, frame_done
    );

    modport slave (
        input  load, hex_in, point_in, blank_in,
        output pending, frame_done
    );
endinterface

// File: rtl/seg7_scan_ctrl_timer.sv
// ---------------------------------------------------------------------------
// seg7_scan_timer: slot timing for the display scan.
//   clk, rst   clock and synchronous active-high reset
//   idx        digit currently being scanned, 0..DIGITS-1
//   guard      high during the first GUARD cycles of each slot
//   tc         prescaler terminal count (last cycle of a slot)
//   frame_end  tc in the last digit's slot (frame boundary)
// GUARD must be smaller than 2^DIV_BITS.
// ---------------------------------------------------------------------------
module seg7_scan_timer
    import seg7_pkg::*;
#(
    parameter int DIGITS   = 8,
    parameter int DIV_BITS = 17,
    parameter int GUARD    = 4,
    parameter int IDX_W    = idx_width(DIGITS)
) (
    input  logic             clk,
    input  logic             rst,
    output logic [IDX_W-1:0] idx,
    output logic             guard,
    output logic             tc,
    output logic             frame_end
);
    localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(DIGITS - 1);
    localparam logic [DIV_BITS-1:0] GUARD_LEN = DIV_BITS'(GUARD);

    logic [DIV_BITS-1:0] presc_q, presc_d;
    logic [IDX_W-1:0]    idx_q, idx_d;

    assign tc        = &presc_q;
    assign frame_end = tc & (idx_q == LAST_IDX);
    assign guard     = (presc_q < GUARD_LEN);
    assign idx       = idx_q;

    always_comb begin
        presc_d = presc_q + 1'b1;   // natural wrap at 2^DIV_BITS
        idx_d   = idx_q;
        if (tc) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            idx_q   <= '0;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
        end
    end
endmodule

// File: rtl/seg7_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg7_scan_ctrl: time-multiplexed scan of a common-anode seven-segment
// display through one shared hex decoder, with double-buffered data.
//   clk, rst   clock and synchronous active-high reset
//   bus        load-side interface (slave modport)
//   dig_hex    nibble for the current digit (decoder D)
//   dig_point  decimal point for the current digit
//   dig_le     decoder blank, 1 = all segments off
//   an         digit anodes, active low
// Loads land in pending registers and are promoted to the shadow (displayed)
// registers only at a frame boundary, so a frame never shows mixed data.
// ---------------------------------------------------------------------------
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int DIGITS   = 8,
    parameter int DIV_BITS = 17,
    parameter int GUARD    = 4
) (
    input  logic                clk,
    input  logic                rst,
    seg7_scan_ctrl_if.slave     bus,
    output logic [3:0]          dig_hex,
    output logic                dig_point,
    output logic                dig_le,
    output logic [DIGITS-1:0]   an
);
    localparam int IDX_W = idx_width(DIGITS);

    logic [IDX_W-1:0] scan_idx;
    logic             scan_guard, scan_tc, scan_frame_end, boundary;

    seg7_scan_timer #(
        .DIGITS   (DIGITS),
        .DIV_BITS (DIV_BITS),
        .GUARD    (GUARD),
        .IDX_W    (IDX_W)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .idx       (scan_idx),
        .guard     (scan_guard),
        .tc        (scan_tc),
        .frame_end (scan_frame_end)
    );

    // frame_end already implies tc; the AND ties the boundary to the slot edge.
    assign boundary = scan_tc & scan_frame_end;

    logic [4*DIGITS-1:0] pend_hex_q,   pend_hex_d;
    logic [DIGITS-1:0]   pend_point_q, pend_point_d;
    logic [DIGITS-1:0]   pend_blank_q, pend_blank_d;
    logic                pending_q,    pending_d;
    logic [4*DIGITS-1:0] shadow_hex_q,   shadow_hex_d;
    logic [DIGITS-1:0]   shadow_point_q, shadow_point_d;
    logic [DIGITS-1:0]   shadow_blank_q, shadow_blank_d;
    logic                frame_done_q;
    logic [DIGITS-1:0]   an_q, an_d;
    nibble_t             dig_hex_q, dig_hex_d;
    logic                dig_point_q, dig_point_d;
    logic                dig_le_q, dig_le_d;

    nibble_t             shadow_nib [DIGITS];

    // Unpack the shadow nibbles and build the active-low anode pattern.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        assign shadow_nib[gi] = shadow_hex_q[4*gi +: 4];
        assign an_d[gi]       = scan_guard | (scan_idx != IDX_W'(gi));
    end

    always_comb begin
        pend_hex_d     = pend_hex_q;
        pend_point_d   = pend_point_q;
        pend_blank_d   = pend_blank_q;
        pending_d      = pending_q;
        shadow_hex_d   = shadow_hex_q;
        shadow_point_d = shadow_point_q;
        shadow_blank_d = shadow_blank_q;

        if (bus.load) begin
            pend_hex_d   = bus.hex_in;
            pend_point_d = bus.point_in;
            pend_blank_d = bus.blank_in;
            pending_d    = 1'b1;
        end

        if (boundary) begin
            // A load on the boundary cycle bypasses the pending stage.
            if (bus.load) begin
                shadow_hex_d   = bus.hex_in;
                shadow_point_d = bus.point_in;
                shadow_blank_d = bus.blank_in;
            end else if (pending_q) begin
                shadow_hex_d   = pend_hex_q;
                shadow_point_d = pend_point_q;
                shadow_blank_d = pend_blank_q;
            end
            pending_d = 1'b0;
        end

        dig_hex_d   = shadow_nib[scan_idx];
        dig_point_d = shadow_point_q[scan_idx];
        dig_le_d    = shadow_blank_q[scan_idx] | scan_guard;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_hex_q     <= '0;
            pend_point_q   <= '0;
            pend_blank_q   <= '0;
            pending_q      <= 1'b0;
            shadow_hex_q   <= '0;
            shadow_point_q <= '0;
            shadow_blank_q <= '1;
            frame_done_q   <= 1'b0;
            an_q           <= ANODE_OFF[DIGITS-1:0];
            dig_hex_q      <= '0;
            dig_point_q    <= 1'b0;
            dig_le_q       <= 1'b1;
        end else begin
            pend_hex_q     <= pend_hex_d;
            pend_point_q   <= pend_point_d;
            pend_blank_q   <= pend_blank_d;
            pending_q      <= pending_d;
            shadow_hex_q   <= shadow_hex_d;
            shadow_point_q <= shadow_point_d;
            shadow_blank_q <= shadow_blank_d;
            frame_done_q   <= boundary;
            an_q           <= an_d;
            dig_hex_q      <= dig_hex_d;
            dig_point_q    <= dig_point_d;
            dig_le_q       <= dig_le_d;
        end
    end

    assign bus.pending    = pending_q;
    assign bus.frame_done = frame_done_q;
    assign an             = an_q;
    assign dig_hex        = dig_hex_q;
    assign dig_point      = dig_point_q;
    assign dig_le         = dig_le_q;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_ctrl: directed bench for seg7_scan_ctrl with DIGITS=8,
// DIV_BITS=3 (8-cycle slots, 64-cycle frames) and GUARD=1.
// 'cyc' counts clock edges since the last reset edge; after each edge the
// outputs reflect the scan state of the previous edge (cyc-1).
// ---------------------------------------------------------------------------
module tb_seg7_scan_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg7_scan_ctrl_if #(.DIGITS(8)) bus ();

    logic [3:0] dig_hex;
    logic       dig_point;
    logic       dig_le;
    logic [7:0] an;

    seg7_scan_ctrl #(
        .DIGITS   (8),
        .DIV_BITS (3),
        .GUARD    (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dig_hex   (dig_hex),
        .dig_point (dig_point),
        .dig_le    (dig_le),
        .an        (an)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive(input logic [31:0] h, input logic [7:0] p, input logic [7:0] b);
        bus.load     = 1'b1;
        bus.hex_in   = h;
        bus.point_in = p;
        bus.blank_in = b;
        $display("load hex=%08h point=%02h blank=%02h at cyc=%0d", h, p, b, cyc);
    endtask

    // One clock, then check every display output against the frame's data.
    task automatic scan_step(input logic [31:0] h, input logic [7:0] p, input logic [7:0] b);
        int         s, pr, ix;
        logic       g;
        logic [7:0] one;
        logic [7:0] ea;
        tick();
        bus.load = 1'b0;
        s   = cyc - 1;
        pr  = s % 8;
        ix  = (s / 8) % 8;
        g   = (pr < 1);
        one = 8'h01;
        ea  = g ? 8'hFF : ~(one << ix);
        chk($sformatf("an@%0d", s),        an,         ea);
        chk($sformatf("dig_hex@%0d", s),   dig_hex,    h[ix*4 +: 4]);
        chk($sformatf("dig_point@%0d", s), dig_point,  p[ix]);
        chk($sformatf("dig_le@%0d", s),    dig_le,     b[ix] | g);
        chk($sformatf("frame_done@%0d", s), bus.frame_done, (cyc % 64) == 0);
    endtask

    initial begin
        bus.load     = 1'b0;
        bus.hex_in   = '0;
        bus.point_in = '0;
        bus.blank_in = '0;

        // 1. Reset for three cycles
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        chk("rst_an",         an,             8'hFF);
        chk("rst_dig_le",     dig_le,         1);
        chk("rst_dig_hex",    dig_hex,        0);
        chk("rst_dig_point",  dig_point,      0);
        chk("rst_pending",    bus.pending,    0);
        chk("rst_frame_done", bus.frame_done, 0);
        $display("reset released");

        // Frame 0: blank shadow; load 76543210 mid-frame (2. load and scan)
        for (int s = 0; s < 64; s++) begin
            if (s == 10) drive(32'h76543210, 8'h01, 8'h00);
            scan_step(32'h0, 8'h00, 8'hFF);
            if (s == 10) chk("pending_set",  bus.pending, 1);
            if (s == 62) chk("pending_hold", bus.pending, 1);
        end
        chk("pending_clr0", bus.pending, 0);
        $display("frame 0 done cyc=%0d", cyc);

        // Frame 1: shows 76543210; load FFFFFFFF at idx 3 (3. tear-free)
        for (int s = 0; s < 64; s++) begin
            if (s == 24) drive(32'hFFFFFFFF, 8'h00, 8'h00);
            scan_step(32'h76543210, 8'h01, 8'h00);
        end
        chk("pending_clr1", bus.pending, 0);
        $display("frame 1 done cyc=%0d", cyc);

        // Frame 2: shows all F; two loads, last wins (4. double load)
        for (int s = 0; s < 64; s++) begin
            if (s == 5)  drive(32'h11111111, 8'h00, 8'h00);
            if (s == 40) drive(32'h22222222, 8'h00, 8'h00);
            scan_step(32'hFFFFFFFF, 8'h00, 8'h00);
            if (s == 62) chk("pending_dbl", bus.pending, 1);
        end
        $display("frame 2 done cyc=%0d", cyc);

        // Frame 3: shows all 2; older data pending, load on boundary (5.)
        for (int s = 0; s < 64; s++) begin
            if (s == 10) drive(32'h33333333, 8'h00, 8'h00);
            if (s == 63) drive(32'hABCDABCD, 8'h00, 8'h00);
            scan_step(32'h22222222, 8'h00, 8'h00);
        end
        chk("pending_sim", bus.pending, 0);
        $display("frame 3 done cyc=%0d", cyc);

        // Frame 4: shows ABCDABCD; load with digits 0..3 blanked (6.)
        for (int s = 0; s < 64; s++) begin
            if (s == 20) drive(32'h89ABCDEF, 8'hF0, 8'h0F);
            scan_step(32'hABCDABCD, 8'h00, 8'h00);
        end
        $display("frame 4 done cyc=%0d", cyc);

        // Frame 5: blanked digits; pending load, then reset at idx 5
        for (int s = 0; s < 40; s++) begin
            if (s == 38) drive(32'h12345678, 8'h00, 8'h00);
            scan_step(32'h89ABCDEF, 8'hF0, 8'h0F);
        end
        chk("pending_pre_rst", bus.pending, 1);
        rst = 1'b1;
        tick();
        chk("mid_rst_an",         an,             8'hFF);
        chk("mid_rst_dig_le",     dig_le,         1);
        chk("mid_rst_pending",    bus.pending,    0);
        chk("mid_rst_frame_done", bus.frame_done, 0);
        chk("mid_rst_dig_hex",    dig_hex,        0);
        rst = 1'b0;
        cyc = 0;
        $display("mid-frame reset applied");

        // Two frames after reset: scan restarts at digit 0, pending discarded
        for (int s = 0; s < 128; s++) begin
            scan_step(32'h0, 8'h00, 8'hFF);
        end
        chk("pending_post_rst", bus.pending, 0);
        $display("post-reset frames done cyc=%0d", cyc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
